// File: rtl/axi_rob_pkg.sv
// Shared types and default sizes for the AR request path between the ROB
// and the AXI slave.
//   ID_WIDTH / ADDR_WIDTH : AXI ARID / ARADDR widths
//   TAG_WIDTH             : tag width, NUM_TAGS = 2**TAG_WIDTH
//   FIFO_DEPTH            : request FIFO entries (power of 2, >= 2)
//   ar_req_t              : one buffered AR request plus its allocated tag
package axi_rob_pkg;

    localparam int ID_WIDTH   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int TAG_WIDTH  = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int NUM_TAGS   = 1 << TAG_WIDTH;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [TAG_WIDTH-1:0]  tagid;
    } ar_req_t;

endpackage

// File: rtl/outgoing_request_buffer_if.sv
// AR request bundle around the outgoing request buffer.
//   in_*  : upstream requests from the ROB path (valid/ready handshake)
//   out_* : AR channel toward the AXI slave, including the allocated tag
// master : the buffer (consumes in_*, drives out_*)
// slave  : the surrounding environment (drives in_*, consumes out_*)
interface outgoing_request_buffer_if;
    import axi_rob_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [ID_WIDTH-1:0]   in_id;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [7:0]            in_len;
    logic [2:0]            in_size;
    logic [1:0]            in_burst;

    logic                  out_valid;
    logic                  out_ready;
    logic [ID_WIDTH-1:0]   out_id;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [7:0]            out_len;
    logic [2:0]            out_size;
    logic [1:0]            out_burst;
    logic [TAG_WIDTH-1:0]  out_tagid;

    modport master (
        input  in_valid, in_id, in_addr, in_len, in_size, in_burst,
        output in_ready,
        output out_valid, out_id, out_addr, out_len, out_size, out_burst, out_tagid,
        input  out_ready
    );

    modport slave (
        output in_valid, in_id, in_addr, in_len, in_size, in_burst,
        input  in_ready,
        input  out_valid, out_id, out_addr, out_len, out_size, out_burst, out_tagid,
        output out_ready
    );

endinterface

// File: rtl/outgoing_request_buffer_fifo.sv
// Synchronous FIFO with count-based pointers and combinational head read.
//   push/wr_data : write when not full
//   pop/rd_data  : rd_data is mem[rd_ptr]; pop advances when not empty
//   full/empty   : derived from the registered count
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/outgoing_request_buffer_tag_free_list.sv
// Tag pool: busy bitmap with lowest-index-free selection.
//   alloc_en   : take alloc_tag this edge (caller guarantees free_count != 0)
//   alloc_tag  : lowest-index free tag, from the pre-edge bitmap
//   rel_valid/rel_tag : return a tag at the clock edge
//   free_count : number of free tags (registered)
//   rel_err    : sticky, set when an already-free tag is released
module tag_free_list #(
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_en,
    output logic [TAG_WIDTH-1:0] alloc_tag,
    input  logic                 rel_valid,
    input  logic [TAG_WIDTH-1:0] rel_tag,
    output logic [TAG_WIDTH:0]   free_count,
    output logic                 rel_err
);

    localparam int NUM_TAGS = 1 << TAG_WIDTH;

    logic [NUM_TAGS-1:0] busy;
    logic                rel_ok;
    logic                rel_dup;

    // Scan downward so the lowest free index is the last one assigned.
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_tag = TAG_WIDTH'(i);
        end
    end

    assign rel_ok  = rel_valid &&  busy[rel_tag];
    assign rel_dup = rel_valid && !busy[rel_tag];

    // A tag freed this edge cannot be the one allocated this edge: the
    // allocator only looks at tags that were already free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            free_count <= (TAG_WIDTH + 1)'(NUM_TAGS);
            rel_err    <= 1'b0;
        end else begin
            if (alloc_en) busy[alloc_tag] <= 1'b1;
            if (rel_ok)   busy[rel_tag]   <= 1'b0;
            case ({alloc_en, rel_ok})
                2'b10:   free_count <= free_count - 1'b1;
                2'b01:   free_count <= free_count + 1'b1;
                default: free_count <= free_count;
            endcase
            if (rel_dup) rel_err <= 1'b1;
        end
    end

endmodule

// File: rtl/outgoing_request_buffer.sv
// Outgoing AR request buffer: tags each accepted request from a free pool,
// queues it, and presents it on a registered AR output stage.
//   clk, rst             : clock, asynchronous active-high reset
//   bus (master)         : in_* upstream handshake, out_* AR channel + tag
//   alloc_valid/tag/id   : one-cycle report of each allocation to the ROB
//   rel_valid/rel_tag    : ROB returns a tag after the last R beat
//   free_count           : free tags remaining
//   rel_err              : sticky double-release flag
module outgoing_request_buffer
    import axi_rob_pkg::*;
#(
    parameter int ID_WIDTH   = axi_rob_pkg::ID_WIDTH,
    parameter int TAG_WIDTH  = axi_rob_pkg::TAG_WIDTH,
    parameter int FIFO_DEPTH = axi_rob_pkg::FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    outgoing_request_buffer_if.master bus,
    output logic                   alloc_valid,
    output logic [TAG_WIDTH-1:0]   alloc_tag,
    output logic [ID_WIDTH-1:0]    alloc_id,
    input  logic                   rel_valid,
    input  logic [TAG_WIDTH-1:0]   rel_tag,
    output logic [TAG_WIDTH:0]     free_count,
    output logic                   rel_err
);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 accept;
    logic                 load;
    logic [TAG_WIDTH-1:0] new_tag;
    ar_req_t              wr_req;
    ar_req_t              head;
    ar_req_t              out_req;
    logic                 out_valid_q;

    // Both terms are registered, so in_ready never depends on in_valid.
    assign bus.in_ready = !fifo_full && (free_count != '0);
    assign accept       = bus.in_valid && bus.in_ready;

    // Refill the output register whenever it is empty or being consumed.
    assign load = !fifo_empty && (!out_valid_q || bus.out_ready);

    always_comb begin
        wr_req       = '0;
        wr_req.id    = bus.in_id;
        wr_req.addr  = bus.in_addr;
        wr_req.len   = bus.in_len;
        wr_req.size  = bus.in_size;
        wr_req.burst = bus.in_burst;
        wr_req.tagid = new_tag;
    end

    tag_free_list #(
        .TAG_WIDTH (TAG_WIDTH)
    ) u_tags (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (accept),
        .alloc_tag  (new_tag),
        .rel_valid  (rel_valid),
        .rel_tag    (rel_tag),
        .free_count (free_count),
        .rel_err    (rel_err)
    );

    fifo #(
        .DATA_WIDTH ($bits(ar_req_t)),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .wr_data (wr_req),
        .pop     (load),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_valid <= 1'b0;
            alloc_tag   <= '0;
            alloc_id    <= '0;
        end else begin
            alloc_valid <= accept;
            if (accept) begin
                alloc_tag <= new_tag;
                alloc_id  <= bus.in_id;
            end
        end
    end

    // Payload only changes on load, so it holds while out_valid && !out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_req     <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_req     <= head;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_req.id;
    assign bus.out_addr  = out_req.addr;
    assign bus.out_len   = out_req.len;
    assign bus.out_size  = out_req.size;
    assign bus.out_burst = out_req.burst;
    assign bus.out_tagid = out_req.tagid;

endmodule

// File: tb/tb_outgoing_request_buffer.sv
// Directed bench for outgoing_request_buffer with hand-computed expectations.
module tb_outgoing_request_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       rel_valid;
    logic [3:0] rel_tag;
    logic       alloc_valid;
    logic [3:0] alloc_tag;
    logic [3:0] alloc_id;
    logic [4:0] free_count;
    logic       rel_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    outgoing_request_buffer_if bus ();

    outgoing_request_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .alloc_valid (alloc_valid),
        .alloc_tag   (alloc_tag),
        .alloc_id    (alloc_id),
        .rel_valid   (rel_valid),
        .rel_tag     (rel_tag),
        .free_count  (free_count),
        .rel_err     (rel_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        bus.in_valid = 1'b1;
        bus.in_id    = id;
        bus.in_addr  = addr;
        bus.in_len   = len;
        bus.in_size  = 3'd2;
        bus.in_burst = 2'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_id     = '0;
        bus.in_addr   = '0;
        bus.in_len    = '0;
        bus.in_size   = '0;
        bus.in_burst  = '0;
        bus.out_ready = 1'b1;
        rel_valid     = 1'b0;
        rel_tag       = '0;
        step();
        step();
        rst = 1'b0;
        #1;

        // reset state
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_alloc_valid", alloc_valid, 0);
        check("rst_rel_err", rel_err, 0);
        check("rst_free_count", free_count, 16);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_addr", bus.out_addr, 0);

        // single request
        drive_req(4'd3, 32'h1000, 8'd7);
        step();
        bus.in_valid = 1'b0;
        check("t1_alloc_valid", alloc_valid, 1);
        check("t1_alloc_tag", alloc_tag, 0);
        check("t1_alloc_id", alloc_id, 3);
        check("t1_out_valid_early", bus.out_valid, 0);
        check("t1_free_count", free_count, 15);
        step();
        check("t1_alloc_pulse", alloc_valid, 0);
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_out_tagid", bus.out_tagid, 0);
        check("t1_out_addr", bus.out_addr, 32'h1000);
        check("t1_out_id", bus.out_id, 3);
        check("t1_out_len", bus.out_len, 7);
        check("t1_out_size", bus.out_size, 2);
        check("t1_out_burst", bus.out_burst, 1);
        step();
        check("t1_out_drain", bus.out_valid, 0);
        rel_valid = 1'b1;
        rel_tag   = 4'd0;
        step();
        rel_valid = 1'b0;
        check("t1_release", free_count, 16);

        // 16 back-to-back requests, tags 0..15 in order
        for (int i = 0; i < 16; i++) begin
            drive_req(4'(i), 32'h2000 + 32'(i * 16), 8'(i));
            check("t2_in_ready", bus.in_ready, 1);
            step();
            check("t2_alloc_tag", alloc_tag, 64'(i));
            if (i > 0) check("t2_out_tagid", bus.out_tagid, 64'(i - 1));
        end
        check("t2_free_count", free_count, 0);
        check("t2_in_ready_17th", bus.in_ready, 0);
        drive_req(4'd1, 32'h2F00, 8'd0);
        step();
        check("t2_no_alloc_17th", alloc_valid, 0);
        check("t2_last_tag", bus.out_tagid, 15);
        bus.in_valid = 1'b0;
        step();
        check("t2_drained", bus.out_valid, 0);

        // all busy, release tag 5, next request gets it
        rel_valid = 1'b1;
        rel_tag   = 4'd5;
        drive_req(4'd9, 32'h5000, 8'd1);
        step();
        rel_valid = 1'b0;
        check("t3_free_after_rel", free_count, 1);
        check("t3_in_ready", bus.in_ready, 1);
        check("t3_no_alloc", alloc_valid, 0);
        step();
        bus.in_valid = 1'b0;
        check("t3_alloc_valid", alloc_valid, 1);
        check("t3_alloc_tag", alloc_tag, 5);
        check("t3_alloc_id", alloc_id, 9);
        check("t3_free_after_alloc", free_count, 0);
        check("t3_in_ready_off", bus.in_ready, 0);
        step();
        check("t3_out_tagid", bus.out_tagid, 5);
        check("t3_out_addr", bus.out_addr, 32'h5000);
        step();
        check("t3_drained", bus.out_valid, 0);

        // double release of tag 2
        rel_valid = 1'b1;
        rel_tag   = 4'd2;
        step();
        check("t4_first_rel_err", rel_err, 0);
        check("t4_first_free", free_count, 1);
        step();
        rel_valid = 1'b0;
        check("t4_dup_rel_err", rel_err, 1);
        check("t4_dup_free", free_count, 1);
        step();
        check("t4_sticky", rel_err, 1);

        // same-cycle alloc + release: tag 1 allocated, tag 0 freed
        rel_valid = 1'b1;
        rel_tag   = 4'd1;
        step();
        check("t5_free_pre", free_count, 2);
        rel_tag = 4'd0;
        drive_req(4'd4, 32'h6000, 8'd2);
        step();
        rel_valid = 1'b0;
        check("t5_alloc_tag", alloc_tag, 1);
        check("t5_free_net", free_count, 2);
        drive_req(4'd6, 32'h6100, 8'd3);
        step();
        bus.in_valid = 1'b0;
        check("t5_freed_tag", alloc_tag, 0);
        check("t5_free_after", free_count, 1);
        check("t5_out_first", bus.out_tagid, 1);
        step();
        check("t5_out_second", bus.out_tagid, 0);
        step();
        check("t5_drained", bus.out_valid, 0);

        // asynchronous reset mid-operation
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_free", free_count, 16);
        check("t6_async_rel_err", rel_err, 0);
        step();
        rst = 1'b0;

        // stalled slave: 9 requests, one in output register, FIFO full
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_req(4'(i), 32'h8000 + 32'(i * 16), 8'd0);
            check("t6_in_ready", bus.in_ready, 1);
            step();
        end
        check("t6_full", bus.in_ready, 0);
        check("t6_out_valid", bus.out_valid, 1);
        check("t6_out_addr", bus.out_addr, 32'h8000);
        check("t6_out_tagid", bus.out_tagid, 0);
        check("t6_free_count", free_count, 7);
        drive_req(4'd9, 32'h8090, 8'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t6_blocked", alloc_valid, 0);
            check("t6_stable_addr", bus.out_addr, 32'h8000);
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("t6_pop_no_push", alloc_valid, 0);
        check("t6_pop_addr", bus.out_addr, 32'h8010);
        check("t6_pop_tag", bus.out_tagid, 1);
        check("t6_ready_again", bus.in_ready, 1);
        for (int i = 2; i < 9; i++) begin
            step();
            check("t6_drain_tag", bus.out_tagid, 64'(i));
        end
        step();
        check("t6_drained", bus.out_valid, 0);
        check("t6_free_final", free_count, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
